universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; SHALL be legal for any value from 2 to 64.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into q by reset.
REQ-003 Port clk  input  1: single clock; all state SHALL update on the rising edge only.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port en  input  1: clock enable; 0 SHALL freeze all state.
REQ-006 Port mode  input  2: operation select; 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port d  input  WIDTH: parallel load data.
REQ-008 Port sin_msb  input  1: serial bit entering q[WIDTH-1] on a right shift.
REQ-009 Port sin_lsb  input  1: serial bit entering q[0] on a left shift.
REQ-010 Port rot  input  1: rotate request; honoured only when USR_ROTATE_EN is defined (REQ-030, REQ-031).
REQ-011 Port q  output  WIDTH: register contents.
REQ-012 Port qbar  output  WIDTH: bitwise complement of q, combinational from q.
REQ-013 Port sout_r  output  1: q[0]. Port sout_l  output  1: q[WIDTH-1].
REQ-014 Port cnt  output  $clog2(WIDTH+1): number of shifts since the last load or reset, saturating.
REQ-015 Port full  output  1: high when cnt == WIDTH.

Function
REQ-016 Priority per edge SHALL be: rst, then en=0 (hold), then mode.
REQ-017 mode 00 with en=1 SHALL leave q and cnt unchanged.
REQ-018 mode 01 with en=1: q SHALL become {sin_msb, q[WIDTH-1:1]}.
REQ-019 mode 10 with en=1: q SHALL become {q[WIDTH-2:0], sin_lsb}.
REQ-020 mode 11 with en=1: q SHALL become d; cnt SHALL become 0.
REQ-021 Each shift with en=1 SHALL increment cnt by 1; at cnt == WIDTH, cnt SHALL hold at WIDTH (no wrap to 0).
REQ-022 Latency: q, cnt and full SHALL reflect an operation one clock after the enabling edge. qbar, sout_l and sout_r SHALL be valid in the same cycle as q.
REQ-023 Direction changes between consecutive shifts SHALL be legal; cnt counts both directions alike.
REQ-024 Unused encodings: none. Every mode value is defined.
REQ-025 Inputs sampled while en=0 SHALL have no effect, including d, sin_msb, sin_lsb and rot.

Reset
REQ-026 rst=1 at a rising edge SHALL set q=RESET_VAL, qbar=~RESET_VAL, cnt=0 and full=0, regardless of en and mode.
REQ-027 Reset asserted mid-shift-sequence SHALL discard the sequence. The first operation after rst deasserts SHALL start from RESET_VAL with cnt=0.
REQ-028 Before the first reset, outputs are undefined; the bench SHALL reset first.

Configuration
REQ-029 Macro USR_ROTATE_EN SHALL select whether rotate support is compiled in.
REQ-030 With USR_ROTATE_EN defined, rot=1 during a shift SHALL replace the serial input with the bit leaving the register: right shift gives {q[0], q[WIDTH-1:1]}, left shift gives {q[WIDTH-2:0], q[WIDTH-1]}. cnt SHALL behave as for a normal shift.
REQ-031 Without USR_ROTATE_EN, rot SHALL be ignored. The port SHALL remain present so that the port list is identical in both builds.

Verification
REQ-032 WIDTH=8: rst=1 for one edge -> q=8'h00, qbar=8'hFF, cnt=0, full=0.
REQ-033 Load d=8'hA5 with mode 11, then 8 right shifts with sin_msb=0 -> q=8'h00 after the 8th edge; sout_r sequence 1,0,1,0,0,1,0,1; cnt=8 and full=1 after the 8th edge; a 9th shift leaves cnt=8.
REQ-034 Load 8'h81, then one left shift with sin_lsb=1 and en=0 -> q stays 8'h81. Repeat with en=1 -> q=8'h03, cnt=1.
REQ-035 With USR_ROTATE_EN defined: load 8'h81, rot=1, one right shift -> q=8'hC0. Without the macro, the same stimulus with sin_msb=0 -> q=8'h40.
REQ-036 Load 8'hFF, 3 left shifts, then rst=1 while mode=10 and en=1 -> q=RESET_VAL and cnt=0. A subsequent load of 8'h3C -> q=8'h3C, cnt=0.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, saturating shift counter.
// Optional rotate support is compiled in when USR_ROTATE_EN is defined.
module universal_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_msb,
    input  logic                       sin_lsb,
    input  logic                       rot,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qbar,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       full
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             full_q, full_d;
    logic             msb_in, lsb_in;

    // Serial inputs: with rotate compiled in, rot recirculates the bit leaving the register.
`ifdef USR_ROTATE_EN
    assign msb_in = rot ? q_q[0]       : sin_msb;
    assign lsb_in = rot ? q_q[WIDTH-1] : sin_lsb;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign msb_in     = sin_msb;
    assign lsb_in     = sin_lsb;
`endif

    assign cnt_inc = (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);

    // Next-state: en=0 freezes everything; every mode encoding is defined.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                MODE_SHR: begin
                    q_d   = {msb_in, q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], lsb_in};
                    cnt_d = cnt_inc;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
            endcase
        end
        full_d = (cnt_d == CW'(WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign q      = q_q;
    assign cnt    = cnt_q;
    assign full   = full_q;
    assign qbar   = ~q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8): directed ops push expected state, a monitor checks.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       sin_msb = 1'b0;
    logic       sin_lsb = 1'b0;
    logic       rot = 1'b0;
    logic [7:0] q, qbar;
    logic       sout_r, sout_l;
    logic [3:0] cnt;
    logic       full;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .rot(rot),
        .q(q), .qbar(qbar), .sout_r(sout_r), .sout_l(sout_l),
        .cnt(cnt), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    // Drive one operation at the negedge, then queue the state expected after the next posedge.
    task automatic op(input logic r, input logic e, input logic [1:0] m, input logic [7:0] dv,
                      input logic smsb, input logic slsb, input logic rt,
                      input logic [7:0] eq, input logic [3:0] ec, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; d = dv; sin_msb = smsb; sin_lsb = slsb; rot = rt;
        @(posedge clk);
        #1;
        x.q = eq; x.cnt = ec; x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are stable between edges, compare at every negedge with a pending expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk(x.name, "q",      q,              x.q);
                chk(x.name, "qbar",   qbar,           ~x.q);
                chk(x.name, "sout_r", {7'b0, sout_r}, {7'b0, x.q[0]});
                chk(x.name, "sout_l", {7'b0, sout_l}, {7'b0, x.q[7]});
                chk(x.name, "cnt",    {4'b0, cnt},    {4'b0, x.cnt});
                chk(x.name, "full",   {7'b0, full},   {7'b0, (x.cnt == 4'd8)});
            end
        end
    end

    initial begin
        logic [7:0] shr_seq [0:8];
        logic [7:0] rot_r, rot_l;
        int budget;
        shr_seq[0] = 8'hA5; shr_seq[1] = 8'h52; shr_seq[2] = 8'h29;
        shr_seq[3] = 8'h14; shr_seq[4] = 8'h0A; shr_seq[5] = 8'h05;
        shr_seq[6] = 8'h02; shr_seq[7] = 8'h01; shr_seq[8] = 8'h00;
`ifdef USR_ROTATE_EN
        rot_r = 8'hC0; rot_l = 8'h03;
`else
        rot_r = 8'h40; rot_l = 8'h02;
`endif
        //  rst   en    mode   d      msb   lsb   rot   exp_q   cnt
        op(1'b1, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "reset");
        op(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, "load_a5");
        for (int i = 1; i <= 8; i++)
            op(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, shr_seq[i], 4'(i), $sformatf("shr%0d", i));
        op(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd8, "shr9_sat");
        op(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 4'd0, "load_81");
        op(1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81, 4'd0, "shl_en0");
        op(1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81, 4'd0, "load_en0");
        op(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h03, 4'd1, "shl_en1");
        op(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 4'd0, "load_81b");
        op(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1, rot_r, 4'd1, "rot_r");
        op(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 4'd0, "load_81c");
        op(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1, rot_l, 4'd1, "rot_l");
        op(1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd0, "load_ff");
        op(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE, 4'd1, "shl1");
        op(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFC, 4'd2, "shl2");
        op(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hF8, 4'd3, "shl3");
        op(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, "mid_rst");
        op(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd0, "load_3c");
        op(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h3C, 4'd0, "hold");
        op(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h9E, 4'd1, "dir_r");
        op(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3D, 4'd2, "dir_l");

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
